// File: rtl/acq_udp_packetizer_pkg.sv
// Shared types and constants for the acquisition UDP packetizer.
// ACQ_SEQ_HEADER_EN selects the sequence-number header state.
package acq_udp_packetizer_pkg;

    localparam int MAX_SAMPLES  = 360;
    localparam int STAT_LEN_LSB = 0;
    localparam int STAT_IP_LSB  = 16;
    localparam int STAT_MAC_LSB = 48;
    localparam int STAT_WIDTH   = 96;

`ifdef ACQ_SEQ_HEADER_EN
    localparam int HDR_BYTES = 4;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_STATUS = 2'd3
    } state_t;
`else
    localparam int HDR_BYTES = 0;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd2,
        ST_STATUS = 2'd3
    } state_t;
`endif

    function automatic logic [STAT_WIDTH-1:0] pack_status(
        input logic [47:0] mac,
        input logic [31:0] ip,
        input logic [15:0] len
    );
        logic [STAT_WIDTH-1:0] s;
        s = '0;
        s[STAT_MAC_LSB +: 48] = mac;
        s[STAT_IP_LSB +: 32]  = ip;
        s[STAT_LEN_LSB +: 16] = len;
        return s;
    endfunction

endpackage

// File: rtl/acq_word_serializer.sv
// Splits a 32-bit word into four bytes, MSB first, one per unstalled cycle.
// last_byte flags the cycle in which the fourth byte is written.
module acq_word_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] word,
    input  logic        word_valid,
    input  logic        stall,
    output logic [7:0]  byte_data,
    output logic        byte_write,
    output logic        last_byte
);

    logic [1:0] idx_q;

    always_comb begin
        byte_write = word_valid && !stall;
        last_byte  = byte_write && (idx_q == 2'd3);
        unique case (idx_q)
            2'd0:    byte_data = word[31:24];
            2'd1:    byte_data = word[23:16];
            2'd2:    byte_data = word[15:8];
            default: byte_data = word[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= 2'd0;
        end else if (byte_write) begin
            idx_q <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/acq_udp_packetizer.sv
// Packs acquisition FIFO words into UDP payload bytes plus a status word.
// Define ACQ_SEQ_HEADER_EN to prepend a 4-byte sequence number per packet.
module acq_udp_packetizer #(
    parameter int SAMPLES_PER_PACKET = 256,
    parameter int UDP_PORT_ID        = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stream_enable,
    input  logic [47:0] destination_mac,
    input  logic [31:0] destination_ip,
    input  logic [31:0] acq_rddata,
    input  logic        acq_rdempty,
    output logic        acq_rdreq,
    output logic [7:0]  tx_fifo_data,
    output logic        tx_fifo_data_write,
    input  logic        tx_fifo_data_full,
    output logic [95:0] tx_fifo_status,
    output logic        tx_fifo_status_write,
    input  logic        tx_fifo_status_full,
    output logic [31:0] packets_sent,
    output logic        busy,
    output logic [15:0] port_id
);
    import acq_udp_packetizer_pkg::*;

    if (SAMPLES_PER_PACKET < 1 || SAMPLES_PER_PACKET > MAX_SAMPLES) begin : g_bad_n
        $error("SAMPLES_PER_PACKET out of range");
    end

    localparam logic [15:0] PAYLOAD_LEN = 16'(4 * SAMPLES_PER_PACKET + HDR_BYTES);
    localparam logic [8:0]  LAST_WORD   = 9'(SAMPLES_PER_PACKET - 1);
`ifdef ACQ_SEQ_HEADER_EN
    localparam state_t FIRST_STATE = ST_HEADER;
`else
    localparam state_t FIRST_STATE = ST_SAMPLE;
`endif

    state_t      state_q, state_d;
    logic [8:0]  word_cnt_q;
    logic [47:0] mac_q;
    logic [31:0] ip_q;
    logic        start;
    logic        ser_valid, ser_write, ser_last;
    logic [31:0] ser_word;
    logic [7:0]  ser_byte;
`ifdef ACQ_SEQ_HEADER_EN
    logic [31:0] seq_num;
`endif

    // Kept apart from the FSM block so ser_last does not loop back into it.
    always_comb begin
        ser_valid = 1'b0;
        ser_word  = acq_rddata;
        if (!reset) begin
            if (state_q == ST_SAMPLE) ser_valid = !acq_rdempty;
`ifdef ACQ_SEQ_HEADER_EN
            if (state_q == ST_HEADER) begin
                ser_valid = 1'b1;
                ser_word  = seq_num;
            end
`endif
        end
    end

    acq_word_serializer u_ser (
        .clk        (clk),
        .reset      (reset),
        .word       (ser_word),
        .word_valid (ser_valid),
        .stall      (tx_fifo_data_full),
        .byte_data  (ser_byte),
        .byte_write (ser_write),
        .last_byte  (ser_last)
    );

    always_comb begin
        state_d              = state_q;
        start                = 1'b0;
        acq_rdreq            = 1'b0;
        tx_fifo_status_write = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ST_IDLE:
                    if (stream_enable && !acq_rdempty && !tx_fifo_status_full) begin
                        start   = 1'b1;
                        state_d = FIRST_STATE;
                    end
`ifdef ACQ_SEQ_HEADER_EN
                ST_HEADER:
                    if (ser_last) state_d = ST_SAMPLE;
`endif
                ST_SAMPLE:
                    if (ser_last) begin
                        acq_rdreq = 1'b1;
                        if (word_cnt_q == LAST_WORD) state_d = ST_STATUS;
                    end
                ST_STATUS:
                    if (!tx_fifo_status_full) begin
                        tx_fifo_status_write = 1'b1;
                        state_d              = ST_IDLE;
                    end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            mac_q        <= '0;
            ip_q         <= '0;
            packets_sent <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                mac_q      <= destination_mac;
                ip_q       <= destination_ip;
                word_cnt_q <= '0;
            end else if (acq_rdreq) begin
                word_cnt_q <= word_cnt_q + 9'd1;
            end
            if (tx_fifo_status_write) packets_sent <= packets_sent + 32'd1;
        end
    end

`ifdef ACQ_SEQ_HEADER_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_num <= '0;
        end else if (tx_fifo_status_write) begin
            seq_num <= seq_num + 32'd1;
        end
    end
`endif

    assign tx_fifo_data       = ser_valid ? ser_byte : 8'h00;
    assign tx_fifo_data_write = ser_write;
    assign tx_fifo_status     = (!reset && state_q == ST_STATUS)
                              ? pack_status(mac_q, ip_q, PAYLOAD_LEN) : '0;
    assign busy               = !reset && (state_q != ST_IDLE);
    assign port_id            = 16'(UDP_PORT_ID);

endmodule

// File: tb/tb_acq_udp_packetizer.sv
// Directed self-checking bench for acq_udp_packetizer with 4-sample packets.
// Header-dependent expectations follow ACQ_SEQ_HEADER_EN.
module tb_acq_udp_packetizer;

    localparam int N = 4;
`ifdef ACQ_SEQ_HEADER_EN
    localparam int HDR = 4;
`else
    localparam int HDR = 0;
`endif
    localparam int NB = 4 * N + HDR;

    logic        clk = 1'b0;
    logic        reset;
    logic        stream_enable;
    logic [47:0] destination_mac;
    logic [31:0] destination_ip;
    logic [31:0] acq_rddata;
    logic        acq_rdempty;
    logic        acq_rdreq;
    logic [7:0]  tx_fifo_data;
    logic        tx_fifo_data_write;
    logic        tx_fifo_data_full;
    logic [95:0] tx_fifo_status;
    logic        tx_fifo_status_write;
    logic        tx_fifo_status_full;
    logic [31:0] packets_sent;
    logic        busy;
    logic [15:0] port_id;

    acq_udp_packetizer #(
        .SAMPLES_PER_PACKET (N),
        .UDP_PORT_ID        (2048)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .stream_enable        (stream_enable),
        .destination_mac      (destination_mac),
        .destination_ip       (destination_ip),
        .acq_rddata           (acq_rddata),
        .acq_rdempty          (acq_rdempty),
        .acq_rdreq            (acq_rdreq),
        .tx_fifo_data         (tx_fifo_data),
        .tx_fifo_data_write   (tx_fifo_data_write),
        .tx_fifo_data_full    (tx_fifo_data_full),
        .tx_fifo_status       (tx_fifo_status),
        .tx_fifo_status_write (tx_fifo_status_write),
        .tx_fifo_status_full  (tx_fifo_status_full),
        .packets_sent         (packets_sent),
        .busy                 (busy),
        .port_id              (port_id)
    );

    always #5 clk = ~clk;

    // Show-ahead acquisition FIFO model
    logic [31:0] mem [0:255];
    int rd_ptr = 0;
    int wr_ptr = 0;
    assign acq_rdempty = (rd_ptr == wr_ptr);
    assign acq_rddata  = mem[rd_ptr % 256];

    logic [7:0]  cap    [0:1023];
    logic [95:0] st_cap [0:31];
    int cap_n = 0;
    int st_n  = 0;
    int viol  = 0;

    always @(posedge clk) begin
        if (tx_fifo_data_write) begin
            cap[cap_n % 1024] <= tx_fifo_data;
            cap_n <= cap_n + 1;
        end
        if (tx_fifo_status_write) begin
            st_cap[st_n % 32] <= tx_fifo_status;
            st_n <= st_n + 1;
        end
        if (acq_rdreq) rd_ptr <= rd_ptr + 1;
        if ((acq_rdreq && acq_rdempty) ||
            (tx_fifo_data_write && tx_fifo_data_full) ||
            (tx_fifo_status_write && tx_fifo_status_full))
            viol <= viol + 1;
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] seq_exp  = 32'h0;
    logic [31:0] pkts_exp = 32'h0;
    logic [7:0]  exp_b [0:63];
    logic [95:0] st_exp;

    task automatic push(input logic [31:0] w);
        mem[wr_ptr % 256] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic make_exp(input logic [31:0] seq, input int first);
        logic [31:0] w;
        for (int i = 0; i < NB; i++) begin
            if (i < HDR) w = seq;
            else w = mem[(first + (i - HDR) / 4) % 256];
            exp_b[i] = w[31 - 8 * (i % 4) -: 8];
        end
        st_exp = {destination_mac, destination_ip, 16'(NB)};
    endtask

    task automatic start_pkt(output bit ok);
        ok = 1'b0;
        @(negedge clk);
        stream_enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        stream_enable = 1'b0;
    endtask

    task automatic wait_bytes(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (cap_n >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_status(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (st_n >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pkt_done();
        seq_exp  = seq_exp + 32'd1;
        pkts_exp = pkts_exp + 32'd1;
    endtask

    task automatic test_reset();
        push(32'hDEADBEEF);
        reset = 1'b1;
        stream_enable = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (acq_rdreq !== 1'b0 || tx_fifo_data_write !== 1'b0 || tx_fifo_status_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b%b%b expected 000",
                     acq_rdreq, tx_fifo_data_write, tx_fifo_status_write);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (tx_fifo_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h expected 00", tx_fifo_data);
        end
        checks++;
        if (tx_fifo_status !== 96'h0) begin
            errors++;
            $display("FAIL reset_status: got %h expected 0", tx_fifo_status);
        end
        checks++;
        if (packets_sent !== 32'h0) begin
            errors++;
            $display("FAIL reset_pkts: got %h expected 0", packets_sent);
        end
        checks++;
        if (port_id !== 16'd2048) begin
            errors++;
            $display("FAIL port_id: got %0d expected 2048", port_id);
        end
        stream_enable = 1'b0;
        wr_ptr = rd_ptr;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int base, sb, first;
        bit ok;
        first = wr_ptr;
        push(32'h11223344);
        push(32'h55667788);
        push(32'h99AABBCC);
        push(32'hDDEEFF00);
        destination_mac = 48'h0A0B0C0D0E0F;
        destination_ip  = 32'hC0A80164;
        make_exp(seq_exp, first);
        base = cap_n;
        sb = st_n;
        start_pkt(ok);
        destination_mac = 48'hFFFFFFFFFFFF;
        destination_ip  = 32'h01020304;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_start: got timeout expected busy");
        end
        wait_status(sb + 1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_status_wait: got timeout expected status write");
        end
        pkt_done();
        checks++;
        if (cap_n - base !== NB) begin
            errors++;
            $display("FAIL basic_len: got %0d expected %0d bytes", cap_n - base, NB);
        end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (cap[(base + i) % 1024] !== exp_b[i]) begin
                errors++;
                $display("FAIL basic_byte%0d: got %h expected %h", i, cap[(base + i) % 1024], exp_b[i]);
            end
        end
        checks++;
        if (st_cap[sb % 32] !== st_exp) begin
            errors++;
            $display("FAIL basic_status: got %h expected %h", st_cap[sb % 32], st_exp);
        end
        checks++;
        if (packets_sent !== pkts_exp) begin
            errors++;
            $display("FAIL basic_pkts: got %0d expected %0d", packets_sent, pkts_exp);
        end
        push(32'hCAFEF00D);
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || st_n !== sb + 1 || cap_n - base !== NB) begin
            errors++;
            $display("FAIL no_restart: got busy=%b st=%0d bytes=%0d expected 0 %0d %0d",
                     busy, st_n, cap_n - base, sb + 1, NB);
        end
        wr_ptr = rd_ptr;
    endtask

    task automatic test_data_stall();
        int base, sb, first;
        bit ok;
        first = wr_ptr;
        push(32'hA1A2A3A4);
        push(32'hB1B2B3B4);
        push(32'hC1C2C3C4);
        push(32'hD1D2D3D4);
        make_exp(seq_exp, first);
        base = cap_n;
        sb = st_n;
        start_pkt(ok);
        wait_bytes(base + 6, ok);
        checks++;
        if (!ok || cap_n - base !== 6) begin
            errors++;
            $display("FAIL stall_reach: got %0d bytes expected 6", cap_n - base);
        end
        tx_fifo_data_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (tx_fifo_data !== exp_b[6] || tx_fifo_data_write !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got %h/%b expected %h/0",
                         k, tx_fifo_data, tx_fifo_data_write, exp_b[6]);
            end
            @(negedge clk);
        end
        tx_fifo_data_full = 1'b0;
        wait_status(sb + 1, ok);
        pkt_done();
        checks++;
        if (!ok || cap_n - base !== NB) begin
            errors++;
            $display("FAIL stall_len: got %0d expected %0d bytes", cap_n - base, NB);
        end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (cap[(base + i) % 1024] !== exp_b[i]) begin
                errors++;
                $display("FAIL stall_byte%0d: got %h expected %h", i, cap[(base + i) % 1024], exp_b[i]);
            end
        end
        checks++;
        if (st_cap[sb % 32] !== st_exp) begin
            errors++;
            $display("FAIL stall_status: got %h expected %h", st_cap[sb % 32], st_exp);
        end
    endtask

    task automatic test_acq_empty();
        int base, sb, first;
        bit ok;
        bit bad;
        first = wr_ptr;
        push(32'h01234567);
        push(32'h89ABCDEF);
        base = cap_n;
        sb = st_n;
        start_pkt(ok);
        wait_bytes(base + HDR + 8, ok);
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tx_fifo_data_full = (k >= 3 && k < 7);
            #1;
            if (acq_rdreq !== 1'b0 || tx_fifo_data_write !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        tx_fifo_data_full = 1'b0;
        checks++;
        if (!ok || bad || busy !== 1'b1 || st_n !== sb || cap_n - base !== HDR + 8) begin
            errors++;
            $display("FAIL empty_wait: got bad=%b busy=%b st=%0d bytes=%0d expected 0 1 %0d %0d",
                     bad, busy, st_n, cap_n - base, sb, HDR + 8);
        end
        push(32'hFEDCBA98);
        push(32'h76543210);
        make_exp(seq_exp, first);
        wait_status(sb + 1, ok);
        pkt_done();
        repeat (5) @(negedge clk);
        checks++;
        if (!ok || st_n !== sb + 1) begin
            errors++;
            $display("FAIL empty_status_count: got %0d expected %0d", st_n - sb, 1);
        end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (cap[(base + i) % 1024] !== exp_b[i]) begin
                errors++;
                $display("FAIL empty_byte%0d: got %h expected %h", i, cap[(base + i) % 1024], exp_b[i]);
            end
        end
    endtask

    task automatic test_status_full();
        int base, sb, first;
        bit ok;
        first = wr_ptr;
        push(32'h0F0E0D0C);
        push(32'h0B0A0908);
        push(32'h07060504);
        push(32'h03020100);
        destination_mac = 48'h112233445566;
        destination_ip  = 32'h0A000001;
        make_exp(seq_exp, first);
        base = cap_n;
        sb = st_n;
        start_pkt(ok);
        tx_fifo_status_full = 1'b1;
        wait_bytes(base + NB, ok);
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (!ok || busy !== 1'b1 || st_n !== sb || tx_fifo_status_write !== 1'b0) begin
            errors++;
            $display("FAIL stfull_hold: got busy=%b st=%0d wr=%b expected 1 %0d 0",
                     busy, st_n, tx_fifo_status_write, sb);
        end
        @(negedge clk);
        tx_fifo_status_full = 1'b0;
        wait_status(sb + 1, ok);
        pkt_done();
        checks++;
        if (!ok || st_cap[sb % 32] !== st_exp) begin
            errors++;
            $display("FAIL stfull_status: got %h expected %h", st_cap[sb % 32], st_exp);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stfull_idle: got busy=%b expected 0", busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (st_n !== sb + 1 || packets_sent !== pkts_exp) begin
            errors++;
            $display("FAIL stfull_single: got %0d writes pkts=%0d expected 1 %0d",
                     st_n - sb, packets_sent, pkts_exp);
        end
    endtask

`ifdef ACQ_SEQ_HEADER_EN
    task automatic test_seq_wrap();
        int base, sb, first;
        bit ok;
        @(negedge clk);
        force dut.seq_num = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.seq_num;
        seq_exp = 32'hFFFFFFFF;
        for (int p = 0; p < 2; p++) begin
            first = wr_ptr;
            push(32'h13579BDF);
            push(32'h2468ACE0);
            push(32'h0F1E2D3C);
            push(32'h4B5A6978);
            make_exp(seq_exp, first);
            base = cap_n;
            sb = st_n;
            start_pkt(ok);
            wait_status(sb + 1, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL wrap%0d_wait: got timeout expected status write", p);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (cap[(base + i) % 1024] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL wrap%0d_hdr%0d: got %h expected %h",
                             p, i, cap[(base + i) % 1024], exp_b[i]);
                end
            end
            pkt_done();
        end
        checks++;
        if (seq_exp !== 32'h1 || packets_sent !== pkts_exp) begin
            errors++;
            $display("FAIL wrap_pkts: got %0d expected %0d", packets_sent, pkts_exp);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int base, sb;
        bit ok;
        push(32'h55AA55AA);
        push(32'h66BB66BB);
        push(32'h77CC77CC);
        push(32'h88DD88DD);
        base = cap_n;
        sb = st_n;
        start_pkt(ok);
        wait_bytes(base + HDR + 5, ok);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (!ok || busy !== 1'b0 || packets_sent !== 32'h0 || tx_fifo_data !== 8'h00 ||
            tx_fifo_status !== 96'h0 || acq_rdreq !== 1'b0 || tx_fifo_data_write !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: got busy=%b pkts=%0d data=%h wr=%b expected 0 0 00 0",
                     busy, packets_sent, tx_fifo_data, tx_fifo_data_write);
        end
        @(negedge clk);
        reset = 1'b0;
        wr_ptr = rd_ptr;
        pkts_exp = 32'h0;
        seq_exp = 32'h0;
        repeat (8) @(negedge clk);
        checks++;
        if (st_n !== sb || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_nostatus: got %0d writes busy=%b expected 0 0", st_n - sb, busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        stream_enable = 1'b0;
        destination_mac = 48'h0;
        destination_ip = 32'h0;
        tx_fifo_data_full = 1'b0;
        tx_fifo_status_full = 1'b0;
        test_reset();
        test_basic();
        test_data_stall();
        test_acq_empty();
        test_status_full();
`ifdef ACQ_SEQ_HEADER_EN
        test_seq_wrap();
`endif
        test_reset_mid();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL protocol: got %0d violations expected 0", viol);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acq_udp_packetizer.md
ACQ_UDP_PACKETIZER -- requirements
Module: acq_udp_packetizer

Interface
REQ-001 Parameter SAMPLES_PER_PACKET, default 256: 32-bit samples per UDP payload; legal range 1..360.
REQ-002 Parameter UDP_PORT_ID, default 2048: constant mirrored on port_id output, for bookkeeping only.
REQ-003 clk  input  1  single clock, the 125 MHz rx_xcvr_clk domain; one clock, reset is synchronous and active-high.
REQ-004 reset  input  1  synchronous active-high reset, driven as ~mac_configured_125.
REQ-005 stream_enable  input  1  level; permits new packets to start.
REQ-006 destination_mac  input  48  client MAC, sampled at packet start.
REQ-007 destination_ip  input  32  client IP, sampled at packet start.
REQ-008 acq_rddata  input  32  show-ahead acquisition FIFO head word.
REQ-009 acq_rdempty  input  1  acquisition FIFO empty.
REQ-010 acq_rdreq  output  1  one-cycle pop of acquisition FIFO.
REQ-011 tx_fifo_data  output  8  payload byte to UDP tx data FIFO.
REQ-012 tx_fifo_data_write  output  1  byte write strobe.
REQ-013 tx_fifo_data_full  input  1  tx data FIFO full.
REQ-014 tx_fifo_status  output  96  {dest_mac[47:0], dest_ip[31:0], payload_len[15:0]}.
REQ-015 tx_fifo_status_write  output  1  status write strobe.
REQ-016 tx_fifo_status_full  input  1  tx status FIFO full.
REQ-017 packets_sent  output  32  count of completed packets.
REQ-018 busy  output  1  high whenever FSM is not IDLE.
REQ-019 port_id  output  16  constant UDP_PORT_ID.

Function
REQ-020 FSM states: IDLE, HEADER, SAMPLE, STATUS; one byte written per cycle maximum.
REQ-021 IDLE -> HEADER (or SAMPLE if header compiled out) when stream_enable & !acq_rdempty & !tx_fifo_status_full; MAC/IP latched that cycle.
REQ-022 HEADER: writes 4 bytes of seq_num MSB first; write asserted only when !tx_fifo_data_full; byte held while full.
REQ-023 SAMPLE: each word emitted as 4 bytes MSB first; acq_rdreq pulses in the cycle the 4th byte is written; if acq_rdempty at a word boundary, no write occurs and FSM waits in SAMPLE.
REQ-024 After SAMPLES_PER_PACKET words -> STATUS; status written only when !tx_fifo_status_full, then -> IDLE; first byte of the next packet no earlier than 1 cycle after status write.
REQ-025 payload_len = 4*SAMPLES_PER_PACKET (+4 with header), 16-bit.
REQ-026 stream_enable deassert mid-packet does not truncate: packet completes; no new packet starts.
REQ-027 Simultaneous tx_fifo_data_full and acq_rdempty: no write, no pop, state held.
REQ-028 packets_sent and seq_num increment by 1 on status write; wrap 0xFFFFFFFF -> 0.
REQ-029 acq_rdreq never asserted when acq_rdempty; tx_fifo_data_write never asserted when tx_fifo_data_full.

Reset
REQ-030 Reset forces IDLE; acq_rdreq, tx_fifo_data_write, tx_fifo_status_write, busy = 0; tx_fifo_data = 0; tx_fifo_status = 0; packets_sent = 0; seq_num = 0.
REQ-031 Reset mid-packet abandons the packet with no status write; downstream FIFO discard is the wrapper's responsibility.

Configuration
REQ-032 Macro ACQ_SEQ_HEADER_EN defined: HEADER state present, 4-byte sequence number prepended, payload_len includes +4.
REQ-033 Macro undefined: HEADER state and seq_num register absent; IDLE -> SAMPLE directly; packets_sent unaffected.

Structure
REQ-034 Shared package holds FSM state encoding, status-word field offsets, and the 360-sample payload limit.
REQ-035 One sub-module acq_word_serializer (32-bit word to 4 bytes with full-stall and last-byte flag) is natural.

Verification
REQ-036 N=4, header on, FIFO preloaded 0x11223344.., no stalls -> 20 bytes 00 00 00 00 11 22 33 44 ..., status len=20, packets_sent=1.
REQ-037 tx_fifo_data_full held 5 cycles mid-word -> same byte held, no duplicate or dropped bytes.
REQ-038 acq FIFO empties after 2 of 4 words, refilled 10 cycles later -> packet completes contiguous, single status write.
REQ-039 tx_fifo_status_full high at end -> remains STATUS, one status write after release, then IDLE.
REQ-040 seq_num preset 0xFFFFFFFF -> header FF FF FF FF, next packet 00 00 00 00; reset mid-packet -> no status write, outputs at reset values.
